// File: rtl/image_renderer.sv
// Purpose : stores an RGB332 image loaded over a valid/ready stream and scans it
//           out, upscaled by 2**SCALE_SHIFT, as 8-bit-per-channel VGA colour.
// Latency : 2 clk_25 cycles from coordinate/sync inputs to colour/sync outputs.
// Backpr. : in_ready is high only in LOAD; a byte transfers when in_valid && in_ready.
//
// Ports:
//   clk_25, n_rst                     pixel clock, async active-low reset
//   x_coordinate, y_coordinate        screen position from the VGA timing generator
//   video_on, hsync, vsync            timing-generator flags aligned with the coordinates
//   load_start, load_abort            single-cycle load commands
//   in_data, in_valid, in_ready       RGB332 load stream and handshake
//   load_done, image_valid            load-complete pulse / image-present level
//   vga_r, vga_g, vga_b               expanded colour, black when not displayable
//   hsync_out, vsync_out, blank_n     timing flags delayed to match the colour
module image_renderer #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2
) (
  input  logic       clk_25,
  input  logic       n_rst,
  input  logic [9:0] x_coordinate,
  input  logic [9:0] y_coordinate,
  input  logic       video_on,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       load_start,
  input  logic       load_abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_done,
  output logic       image_valid,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       blank_n
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Load FSM
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic [AW-1:0] waddr_q;
  logic          in_ready_q;
  logic          load_done_q;
  logic          image_valid_q;
  logic          wr_en;

  // Abort wins over a coincident valid byte, so that byte is never written.
  assign wr_en = (state_q == LOAD) && in_valid && !load_abort;

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      waddr_q       <= '0;
      in_ready_q    <= 1'b0;
      load_done_q   <= 1'b0;
      image_valid_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q       <= LOAD;
            waddr_q       <= '0;
            in_ready_q    <= 1'b1;
            image_valid_q <= 1'b0;
          end
        end
        LOAD: begin
          if (load_abort) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b0;
            image_valid_q <= 1'b0;
          end else if (in_valid) begin
            waddr_q <= waddr_q + AW'(1);
            if (waddr_q == LAST_ADDR) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q       <= IDLE;
          image_valid_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign load_done   = load_done_q;
  assign image_valid = image_valid_q;

  // ---------------------------------------------------------------------------
  // Image memory: contents are not reset; image_valid gates the output instead.
  // ---------------------------------------------------------------------------
  logic [7:0] mem [NPIX];

  always_ff @(posedge clk_25) begin
    if (wr_en) begin
      mem[waddr_q] <= in_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline stage 1: image coordinate, range check, address
  // ---------------------------------------------------------------------------
  logic [9:0]    x_img;
  logic [9:0]    y_img;
  logic          in_range;
  logic [AW-1:0] raddr_d;

  assign x_img    = x_coordinate >> SCALE_SHIFT;
  assign y_img    = y_coordinate >> SCALE_SHIFT;
  assign in_range = (32'(x_img) < 32'(IMG_W)) && (32'(y_img) < 32'(IMG_H));
  // Out-of-range pixels read address 0 so the memory is never indexed past its end.
  assign raddr_d  = in_range ? AW'(32'(y_img) * 32'(IMG_W) + 32'(x_img)) : '0;

  logic [AW-1:0] raddr_q;
  logic          oor1_q, hs1_q, vs1_q, von1_q;
  logic [7:0]    rdata_q;
  logic          oor2_q, hs2_q, vs2_q, von2_q;

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      raddr_q <= '0;
      oor1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      von1_q  <= 1'b0;
      rdata_q <= 8'h00;
      oor2_q  <= 1'b0;
      hs2_q   <= 1'b0;
      vs2_q   <= 1'b0;
      von2_q  <= 1'b0;
    end else begin
      raddr_q <= raddr_d;
      oor1_q  <= !in_range;
      hs1_q   <= hsync;
      vs1_q   <= vsync;
      von1_q  <= video_on;
      // Stage 2: read data (old contents on a same-address write) plus flags.
      rdata_q <= mem[raddr_q];
      oor2_q  <= oor1_q;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      von2_q  <= von1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Output: RGB332 expanded by bit replication, black unless a complete image
  // is present, no load is running and the pixel is visible and in range.
  // ---------------------------------------------------------------------------
  logic pix_en;

  assign pix_en    = von2_q && image_valid_q && (state_q == IDLE) && !oor2_q;
  assign vga_r     = pix_en ? {rdata_q[7:5], rdata_q[7:5], rdata_q[7:6]} : 8'h00;
  assign vga_g     = pix_en ? {rdata_q[4:2], rdata_q[4:2], rdata_q[4:3]} : 8'h00;
  assign vga_b     = pix_en ? {4{rdata_q[1:0]}} : 8'h00;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign blank_n   = von2_q;

endmodule

// File: tb/tb_image_renderer.sv
// Purpose : directed self-checking bench for image_renderer (160x120, x4 upscale).
// Latency : expects colour and sync outputs 2 clk_25 cycles after their inputs.
// Backpr. : drives the load stream with held and gapped in_valid against in_ready.
module tb_image_renderer;

  localparam int NPIX = 160 * 120;

  logic       clk_25;
  logic       n_rst;
  logic [9:0] x_coordinate;
  logic [9:0] y_coordinate;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       load_start;
  logic       load_abort;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       load_done;
  logic       image_valid;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       hsync_out;
  logic       vsync_out;
  logic       blank_n;

  int checks = 0;
  int errors = 0;

  image_renderer #(
    .IMG_W      (160),
    .IMG_H      (120),
    .SCALE_SHIFT(2)
  ) dut (
    .clk_25      (clk_25),
    .n_rst       (n_rst),
    .x_coordinate(x_coordinate),
    .y_coordinate(y_coordinate),
    .video_on    (video_on),
    .hsync       (hsync),
    .vsync       (vsync),
    .load_start  (load_start),
    .load_abort  (load_abort),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .load_done   (load_done),
    .image_valid (image_valid),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .blank_n     (blank_n)
  );

  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Image content: byte 0 red, last byte green, everything else the low address byte.
  function automatic logic [7:0] pat(input int n);
    logic [31:0] nv;
    nv = n;
    if (n == 0) return 8'hE0;
    if (n == NPIX - 1) return 8'h1C;
    return nv[7:0];
  endfunction

  // Present a pixel and wait until its colour reaches the outputs.
  task automatic show(input int x, input int y, input logic von);
    x_coordinate = 10'(x);
    y_coordinate = 10'(y);
    video_on     = von;
    @(negedge clk_25);
    @(negedge clk_25);
  endtask

  // Full load: load_start with a junk valid byte in the same IDLE cycle, then
  // pat(0..NPIX-1) with optional random gaps and an optional stray load_start.
  task automatic do_load(input int gap_pct, input int ls_at,
                         output int rdy_cnt, output int done_cnt,
                         output int last_c, output int done_c, output int nwr);
    int n;
    int c;
    n = 0;
    c = 0;
    rdy_cnt = 0;
    done_cnt = 0;
    last_c = -1;
    done_c = -1;
    @(negedge clk_25);
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h55;
    while (c < 30000 && !(n == NPIX && c > last_c + 4)) begin
      @(negedge clk_25);
      c++;
      load_start = (c == ls_at);
      if (in_ready) rdy_cnt++;
      if (load_done) begin
        done_cnt++;
        done_c = c;
      end
      if (n < NPIX && $urandom_range(99) >= gap_pct) begin
        in_valid = 1'b1;
        in_data  = pat(n);
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      if (in_ready && in_valid) begin
        n++;
        last_c = c;
      end
    end
    in_valid   = 1'b0;
    load_start = 1'b0;
    nwr = n;
  endtask

  logic hh[2];
  logic vh[2];
  logic oh[2];
  int   rdy_cnt, done_cnt, last_c, done_c, nwr;

  initial begin
    n_rst        = 1'b0;
    x_coordinate = 10'd0;
    y_coordinate = 10'd0;
    video_on     = 1'b1;
    hsync        = 1'b1;
    vsync        = 1'b1;
    load_start   = 1'b0;
    load_abort   = 1'b0;
    in_data      = 8'h00;
    in_valid     = 1'b0;

    // Reset with active timing inputs: every output stays low.
    repeat (3) @(negedge clk_25);
    chk("rst_hsync_out", 32'(hsync_out), 32'd0);
    chk("rst_vsync_out", 32'(vsync_out), 32'd0);
    chk("rst_blank_n", 32'(blank_n), 32'd0);
    chk("rst_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_image_valid", 32'(image_valid), 32'd0);

    video_on = 1'b0;
    hsync    = 1'b0;
    vsync    = 1'b0;
    n_rst    = 1'b1;
    repeat (2) @(negedge clk_25);

    // No image loaded: random timing, outputs are the inputs two cycles late, colour black.
    for (int i = 0; i < 2; i++) begin
      hh[i] = 1'b0;
      vh[i] = 1'b0;
      oh[i] = 1'b0;
    end
    for (int k = 0; k < 48; k++) begin
      @(negedge clk_25);
      chk("frm_hsync_out", 32'(hsync_out), 32'(hh[1]));
      chk("frm_vsync_out", 32'(vsync_out), 32'(vh[1]));
      chk("frm_blank_n", 32'(blank_n), 32'(oh[1]));
      chk("frm_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
      hsync        = 1'($urandom_range(1));
      vsync        = 1'($urandom_range(1));
      video_on     = 1'($urandom_range(1));
      x_coordinate = 10'($urandom_range(799));
      y_coordinate = 10'($urandom_range(524));
      hh[1] = hh[0]; hh[0] = hsync;
      vh[1] = vh[0]; vh[0] = vsync;
      oh[1] = oh[0]; oh[0] = video_on;
    end
    hsync = 1'b0;
    vsync = 1'b0;

    // Held in_valid load.
    do_load(0, -1, rdy_cnt, done_cnt, last_c, done_c, nwr);
    chk("ld1_writes", 32'(nwr), 32'(NPIX));
    chk("ld1_ready_cycles", 32'(rdy_cnt), 32'd19200);
    chk("ld1_done_pulses", 32'(done_cnt), 32'd1);
    chk("ld1_done_timing", 32'(done_c), 32'(last_c + 1));
    chk("ld1_image_valid", 32'(image_valid), 32'd1);
    chk("ld1_in_ready_idle", 32'(in_ready), 32'd0);

    // Byte sent with load_start is dropped: address 0 holds E0, not 55.
    show(0, 0, 1'b1);
    chk("p00_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h00FF0000);
    chk("p00_blank_n", 32'(blank_n), 32'd1);
    show(4, 0, 1'b1);
    chk("p10_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h00000055);
    show(23, 9, 1'b1);
    chk("p52_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h00492455);

    // Abort after 100 bytes.
    @(negedge clk_25);
    load_start = 1'b1;
    @(negedge clk_25);
    load_start = 1'b0;
    chk("ab_in_ready_load", 32'(in_ready), 32'd1);
    chk("ab_image_valid_load", 32'(image_valid), 32'd0);
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
      @(negedge clk_25);
    end
    chk("ab_rgb_loading", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    load_abort = 1'b1;
    in_data    = 8'h00;
    @(negedge clk_25);
    load_abort = 1'b0;
    in_valid   = 1'b1;
    chk("ab_in_ready", 32'(in_ready), 32'd0);
    chk("ab_image_valid", 32'(image_valid), 32'd0);
    chk("ab_load_done", 32'(load_done), 32'd0);
    @(negedge clk_25);
    in_valid = 1'b0;
    chk("ab_in_ready_idle", 32'(in_ready), 32'd0);
    show(0, 0, 1'b1);
    chk("ab_rgb_black", {8'h00, vga_r, vga_g, vga_b}, 32'd0);

    // Gapped load with a stray load_start part way through.
    do_load(25, 500, rdy_cnt, done_cnt, last_c, done_c, nwr);
    chk("ld2_writes", 32'(nwr), 32'(NPIX));
    chk("ld2_done_pulses", 32'(done_cnt), 32'd1);
    chk("ld2_done_timing", 32'(done_c), 32'(last_c + 1));
    chk("ld2_image_valid", 32'(image_valid), 32'd1);

    // Exact 2-cycle latency on a black-to-red transition.
    show(0, 0, 1'b0);
    chk("lat_blank", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    video_on = 1'b1;
    @(negedge clk_25);
    chk("lat_cycle1_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    chk("lat_cycle1_blank_n", 32'(blank_n), 32'd0);
    @(negedge clk_25);
    chk("lat_cycle2_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h00FF0000);
    chk("lat_cycle2_blank_n", 32'(blank_n), 32'd1);

    // Image pixel (0,0) covers screen 0..3 x 0..3.
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        show(x, y, 1'b1);
        chk("red_block_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h00FF0000);
      end
    end

    // Bottom-right image pixel and range limits.
    show(636, 476, 1'b1);
    chk("br_636_476_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h0000FF00);
    show(639, 479, 1'b1);
    chk("br_639_479_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h0000FF00);
    show(640, 0, 1'b1);
    chk("oor_x640", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    show(0, 480, 1'b1);
    chk("oor_y480", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    show(23, 9, 1'b1);
    chk("ld2_p52_rgb", {8'h00, vga_r, vga_g, vga_b}, 32'h00492455);

    // Reset in the middle of a load.
    hsync = 1'b1;
    vsync = 1'b1;
    @(negedge clk_25);
    load_start = 1'b1;
    @(negedge clk_25);
    load_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
      @(negedge clk_25);
    end
    chk("mr_hsync_before", 32'(hsync_out), 32'd1);
    in_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk("mr_async_hsync_out", 32'(hsync_out), 32'd0);
    chk("mr_async_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk_25);
    n_rst = 1'b1;
    @(negedge clk_25);
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    chk("mr_image_valid", 32'(image_valid), 32'd0);
    show(0, 0, 1'b1);
    chk("mr_rgb_black", {8'h00, vga_r, vga_g, vga_b}, 32'd0);
    chk("mr_hsync_after", 32'(hsync_out), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_renderer.md
IMAGE_RENDERER -- requirements
Module: image_renderer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 160, meaning stored image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 120, meaning stored image height in pixels.
REQ-003 The block SHALL have parameter SCALE_SHIFT, default 2, meaning the log2 upscale factor from screen coordinates to image coordinates.
REQ-004 The block SHALL have port clk_25, input, 1 bit: the pixel clock.
REQ-005 The block SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports x_coordinate and y_coordinate, input, 10 bits each: the current pixel position from the VGA timing generator.
REQ-007 The block SHALL have ports video_on, hsync and vsync, input, 1 bit each: timing-generator outputs aligned with the coordinates.
REQ-008 The block SHALL have ports load_start and load_abort, input, 1 bit each: single-cycle load commands.
REQ-009 The block SHALL have port in_data, input, 8 bits: an RGB332 pixel byte (R[7:5], G[4:2], B[1:0]).
REQ-010 The block SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: the load handshake.
REQ-011 The block SHALL have ports load_done (1-cycle pulse) and image_valid (level), output, 1 bit each.
REQ-012 The block SHALL have ports vga_r, vga_g and vga_b, output, 8 bits each, plus ports hsync_out, vsync_out and blank_n, output, 1 bit each.

Function
REQ-013 The block SHALL contain an IMG_W*IMG_H x 8-bit memory with one synchronous-read port and one write port.
REQ-014 The load FSM SHALL have three states, IDLE, LOAD and DONE, and SHALL enter IDLE on reset.
REQ-015 In IDLE, load_start=1 SHALL clear the write address to 0 and move the FSM to LOAD; all other inputs are ignored.
REQ-016 In LOAD, in_ready SHALL be 1, and each cycle with in_valid=1 SHALL write in_data at the write address and increment it by 1.
REQ-017 When the write at address IMG_W*IMG_H-1 is accepted, the FSM SHALL move to DONE.
REQ-018 in_ready SHALL be 0 in IDLE and in DONE.
REQ-019 DONE SHALL last exactly 1 cycle, assert load_done for that cycle, set image_valid=1 and return to IDLE.
REQ-020 In LOAD, load_start SHALL be ignored.
REQ-021 In LOAD, load_abort=1 SHALL return the FSM to IDLE, clear image_valid and suppress any write in that cycle; load_abort takes priority over in_valid.
REQ-022 Entering LOAD SHALL clear image_valid.
REQ-023 Read pipeline stage 1 SHALL register the read address ((y_coordinate>>SCALE_SHIFT)*IMG_W + (x_coordinate>>SCALE_SHIFT)), with address width ceil(log2(IMG_W*IMG_H)).
REQ-024 For coordinates whose image x is at or beyond IMG_W, or image y is at or beyond IMG_H, stage 1 SHALL flag the pixel out-of-range, and that pixel SHALL output black.
REQ-025 Stage 2 SHALL register the memory read data together with the delayed flags.
REQ-026 The total latency from the input coordinate and sync signals to the outputs SHALL be exactly 2 clk_25 cycles.
REQ-027 hsync, vsync and video_on SHALL be delayed through 2 registers to drive hsync_out, vsync_out and blank_n respectively, with polarity unchanged.
REQ-028 Colour expansion SHALL be vga_r = {R,R,R[2:1]}, vga_g = {G,G,G[2:1]} and vga_b = {B,B,B,B}.
REQ-029 The colour outputs SHALL be 0 whenever the delayed video_on is 0, image_valid is 0, the FSM is not IDLE, or the pixel is out-of-range.
REQ-030 A write and a read of the same address in the same cycle SHALL return the old data (read-before-write).

Reset
REQ-031 While n_rst=0, all outputs SHALL be 0, the FSM SHALL be IDLE, the write address SHALL be 0, and the pipeline registers SHALL be cleared.
REQ-032 Memory contents SHALL NOT be reset; image_valid=0 guarantees black output until a full load completes.
REQ-033 Reset asserted mid-LOAD SHALL abandon the load; after release, the block SHALL be in IDLE with image_valid=0.

Verification
REQ-034 Reset, then a full frame is fed -> all colour outputs are 0, blank_n follows video_on delayed by 2 cycles, and hsync_out and vsync_out equal hsync and vsync delayed by 2 cycles.
REQ-035 load_start, then 19200 bytes with in_valid held at 1 -> in_ready=1 for 19200 cycles, load_done pulses once in the cycle after the last write, and image_valid=1.
REQ-036 A load with random in_valid gaps, byte 0 = 8'hE0 -> at x=0..3, y=0..3 the output 2 cycles later is vga_r=8'hFF, vga_g=0, vga_b=0.
REQ-037 Byte 8'h1C stored at image (159,119) -> pixel (636,476) shows vga_g=8'hFF; pixel (639,479) shows the same colour.
REQ-038 load_abort after 100 bytes -> FSM is IDLE, image_valid=0, output is black, and in_ready=0 on the next cycle.
REQ-039 load_start and in_valid asserted in the same IDLE cycle -> no write occurs; the first write lands in the next cycle at address 0.
